// File: rtl/wb_trace_checker.sv
// wb_trace_checker: merges N writeback slots into program order, queues the commits and
// checks them one per cycle against a golden trace. Define WB_TRACE_PERF_EN for cycle_cnt.
//   state   | meaning
//   S_RUN   | accepting commits and comparing against the golden stream
//   S_DRAIN | end seen; no new commits, comparing until the queue is empty
//   S_DONE  | queue drained without error (terminal until rst)
//   S_ERR   | mismatch or overflow seen (terminal until rst)
module wb_trace_checker #(
    parameter int          ISSUE_W = 2,
    parameter int          DEPTH   = 8,
    parameter logic [31:0] END_PC  = 32'hbfc00100,
    localparam int         FW      = (ISSUE_W > 1) ? $clog2(ISSUE_W) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [32*ISSUE_W-1:0]  wb_pc,
    input  logic [4*ISSUE_W-1:0]   wb_rf_wen,
    input  logic [5*ISSUE_W-1:0]   wb_rf_wnum,
    input  logic [32*ISSUE_W-1:0]  wb_rf_wdata,
    input  logic [FW-1:0]          wb_first,
    input  logic                   uart_valid,
    input  logic [7:0]             uart_data,
    input  logic                   ref_valid,
    output logic                   ref_ready,
    input  logic [31:0]            ref_pc,
    input  logic [4:0]             ref_wnum,
    input  logic [31:0]            ref_wdata,
    output logic                   done,
    output logic                   pass,
    output logic                   err,
    output logic [31:0]            err_pc,
    output logic [31:0]            err_wdata,
    output logic [31:0]            commit_cnt,
    output logic [31:0]            cycle_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = $clog2(ISSUE_W + 1);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nx;

    logic [31:0]   r_mem_pc    [DEPTH];
    logic [4:0]    r_mem_wnum  [DEPTH];
    logic [31:0]   r_mem_wdata [DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [31:0]   r_err_pc;
    logic [31:0]   r_err_wdata;
    logic [31:0]   r_commit_cnt;

    logic [31:0]   w_rot_pc    [ISSUE_W];
    logic [4:0]    w_rot_wnum  [ISSUE_W];
    logic [31:0]   w_rot_wdata [ISSUE_W];
    logic          w_rot_q     [ISSUE_W];
    logic [31:0]   w_pk_pc     [ISSUE_W];
    logic [4:0]    w_pk_wnum   [ISSUE_W];
    logic [31:0]   w_pk_wdata  [ISSUE_W];
    logic [AW-1:0] w_waddr     [ISSUE_W];
    logic [KW-1:0] w_k;
    logic [PW-1:0] w_used;
    logic [PW-1:0] w_free;
    logic          w_empty;
    logic          w_trig;
    logic          w_ovf;
    logic          w_enq;
    logic          w_ready;
    logic          w_mism;
    logic [31:0]   w_head_pc;
    logic [4:0]    w_head_wnum;
    logic [31:0]   w_head_wdata;

    function automatic int slot_of(input logic [FW-1:0] first, input int s);
        return (int'(first) + s) % ISSUE_W;
    endfunction

    always_comb begin
        for (int s = 0; s < ISSUE_W; s++) begin
            w_rot_pc[s]    = wb_pc[32*slot_of(wb_first, s) +: 32];
            w_rot_wnum[s]  = wb_rf_wnum[5*slot_of(wb_first, s) +: 5];
            w_rot_wdata[s] = wb_rf_wdata[32*slot_of(wb_first, s) +: 32];
            w_rot_q[s]     = (wb_rf_wen[4*slot_of(wb_first, s) +: 4] != 4'd0) && (w_rot_wnum[s] != 5'd0);
        end
    end

    // Pack qualifying commits contiguously, oldest first.
    always_comb begin
        w_k = '0;
        for (int p = 0; p < ISSUE_W; p++) begin
            w_pk_pc[p]    = '0;
            w_pk_wnum[p]  = '0;
            w_pk_wdata[p] = '0;
        end
        for (int s = 0; s < ISSUE_W; s++) begin
            if (w_rot_q[s]) begin
                for (int p = 0; p < ISSUE_W; p++) begin
                    if (w_k == KW'(p)) begin
                        w_pk_pc[p]    = w_rot_pc[s];
                        w_pk_wnum[p]  = w_rot_wnum[s];
                        w_pk_wdata[p] = w_rot_wdata[s];
                    end
                end
                w_k = w_k + KW'(1);
            end
        end
    end

    always_comb begin
        w_trig = uart_valid && (uart_data == 8'hff);
        for (int s = 0; s < ISSUE_W; s++) begin
            if (wb_pc[32*s +: 32] == END_PC) begin
                w_trig = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < ISSUE_W; g++) begin : g_waddr
        assign w_waddr[g] = r_wptr[AW-1:0] + AW'(g);
    end

    assign w_empty      = (r_wptr == r_rptr);
    assign w_used       = r_wptr - r_rptr;
    assign w_free       = PW'(DEPTH) - w_used;
    assign w_head_pc    = r_mem_pc[r_rptr[AW-1:0]];
    assign w_head_wnum  = r_mem_wnum[r_rptr[AW-1:0]];
    assign w_head_wdata = r_mem_wdata[r_rptr[AW-1:0]];

    // Free space is judged on this cycle's occupancy; a same-cycle dequeue does not help.
    assign w_ovf   = (r_state == S_RUN) && (PW'(w_k) > w_free);
    assign w_enq   = (r_state == S_RUN) && !w_ovf;
    assign w_ready = ((r_state == S_RUN) || (r_state == S_DRAIN)) && !w_empty && ref_valid;
    assign w_mism  = w_ready && ((w_head_pc != ref_pc) || (w_head_wnum != ref_wnum) ||
                                 (w_head_wdata != ref_wdata));

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_RUN:   if (w_trig)  w_state_nx = S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nx = S_DONE;
            default: w_state_nx = r_state;
        endcase
        if (w_ovf || w_mism) begin
            w_state_nx = S_ERR;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_err_pc     <= '0;
            r_err_wdata  <= '0;
            r_commit_cnt <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_enq) begin
                r_wptr <= r_wptr + PW'(w_k);
            end
            if (w_ready) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_ready && !w_mism) begin
                r_commit_cnt <= r_commit_cnt + 32'd1;
            end
            if (w_mism) begin
                r_err_pc    <= w_head_pc;
                r_err_wdata <= w_head_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_enq) begin
            for (int p = 0; p < ISSUE_W; p++) begin
                if (KW'(p) < w_k) begin
                    r_mem_pc[w_waddr[p]]    <= w_pk_pc[p];
                    r_mem_wnum[w_waddr[p]]  <= w_pk_wnum[p];
                    r_mem_wdata[w_waddr[p]] <= w_pk_wdata[p];
                end
            end
        end
    end

`ifdef WB_TRACE_PERF_EN
    logic [31:0] r_cycle_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt <= '0;
        end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
        end
    end

    assign cycle_cnt = r_cycle_cnt;
`else
    assign cycle_cnt = 32'd0;
`endif

    assign ref_ready  = w_ready;
    assign done       = (r_state == S_DONE) || (r_state == S_ERR);
    assign pass       = (r_state == S_DONE);
    assign err        = (r_state == S_ERR);
    assign err_pc     = r_err_pc;
    assign err_wdata  = r_err_wdata;
    assign commit_cnt = r_commit_cnt;

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: queue-based reference model compared every cycle, plus
// directed scenarios with literal expectations. Honours WB_TRACE_PERF_EN for cycle_cnt.
module tb_wb_trace_checker;

    localparam int          ISSUE_W = 2;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] END_PC  = 32'hbfc00100;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [63:0]  wb_pc;
    logic [7:0]   wb_rf_wen;
    logic [9:0]   wb_rf_wnum;
    logic [63:0]  wb_rf_wdata;
    logic [0:0]   wb_first;
    logic         uart_valid;
    logic [7:0]   uart_data;
    logic         ref_valid;
    logic         ref_ready;
    logic [31:0]  ref_pc;
    logic [4:0]   ref_wnum;
    logic [31:0]  ref_wdata;
    logic         done, pass, err;
    logic [31:0]  err_pc, err_wdata, commit_cnt, cycle_cnt;

    int n_checks = 0;
    int n_errs   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    wb_trace_checker #(.ISSUE_W(ISSUE_W), .DEPTH(DEPTH), .END_PC(END_PC)) dut (
        .clk(clk), .rst(rst), .wb_pc(wb_pc), .wb_rf_wen(wb_rf_wen), .wb_rf_wnum(wb_rf_wnum),
        .wb_rf_wdata(wb_rf_wdata), .wb_first(wb_first), .uart_valid(uart_valid),
        .uart_data(uart_data), .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_pc(ref_pc),
        .ref_wnum(ref_wnum), .ref_wdata(ref_wdata), .done(done), .pass(pass), .err(err),
        .err_pc(err_pc), .err_wdata(err_wdata), .commit_cnt(commit_cnt), .cycle_cnt(cycle_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: program-order record queue plus end/err/done flags.
    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  wnum;
        logic [31:0] wd;
    } rec_t;

    rec_t        mq[$];
    bit          m_drain, m_done, m_err;
    logic [31:0] m_err_pc, m_err_wd, m_commits, m_cycles;

    task automatic model_step();
        int   size0;
        int   slot;
        bit   bad;
        bit   trig;
        rec_t h;
        rec_t inc[$];
        if (rst) begin
            mq.delete();
            m_drain = 0; m_done = 0; m_err = 0;
            m_err_pc = 0; m_err_wd = 0; m_commits = 0; m_cycles = 0;
            return;
        end
        if (m_done || m_err) return;
`ifdef WB_TRACE_PERF_EN
        m_cycles += 1;
`endif
        size0 = mq.size();
        bad   = 0;
        if (size0 != 0 && ref_valid) begin
            h = mq.pop_front();
            if (h.pc !== ref_pc || h.wnum !== ref_wnum || h.wd !== ref_wdata) begin
                bad = 1; m_err_pc = h.pc; m_err_wd = h.wd;
            end else begin
                m_commits += 1;
            end
        end
        if (!m_drain) begin
            trig = uart_valid && uart_data == 8'hff;
            for (int s = 0; s < ISSUE_W; s++) begin
                slot = (int'(wb_first) + s) % ISSUE_W;
                if (wb_rf_wen[4*slot +: 4] != 0 && wb_rf_wnum[5*slot +: 5] != 0)
                    inc.push_back('{wb_pc[32*slot +: 32], wb_rf_wnum[5*slot +: 5], wb_rf_wdata[32*slot +: 32]});
                if (wb_pc[32*s +: 32] == END_PC) trig = 1;
            end
            if (inc.size() > DEPTH - size0) bad = 1;
            else foreach (inc[i]) mq.push_back(inc[i]);
            if (trig) m_drain = 1;
        end else if (size0 == 0) begin
            m_done = 1;
        end
        if (bad) m_err = 1;
    endtask

    always @(posedge clk) model_step();

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ref_ready", ref_ready, !m_done && !m_err && mq.size() != 0 && ref_valid);
            chk("done", done, m_done || m_err);
            chk("pass", pass, m_done && !m_err);
            chk("err", err, m_err);
            chk("err_pc", err_pc, m_err_pc);
            chk("err_wdata", err_wdata, m_err_wd);
            chk("commit_cnt", commit_cnt, m_commits);
            chk("cycle_cnt", cycle_cnt, m_cycles);
        end
    end

    task automatic idle_in();
        wb_pc = '0; wb_rf_wen = '0; wb_rf_wnum = '0; wb_rf_wdata = '0;
        uart_valid = 0; uart_data = '0;
        ref_valid = 0; ref_pc = '0; ref_wnum = '0; ref_wdata = '0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_slot(input int s, input logic [31:0] pc, input logic [3:0] wen,
                            input logic [4:0] wnum, input logic [31:0] d);
        wb_pc[32*s +: 32] = pc;
        wb_rf_wen[4*s +: 4] = wen;
        wb_rf_wnum[5*s +: 5] = wnum;
        wb_rf_wdata[32*s +: 32] = d;
    endtask

    task automatic set_ref(input logic [31:0] pc, input logic [4:0] wnum, input logic [31:0] d);
        ref_valid = 1; ref_pc = pc; ref_wnum = wnum; ref_wdata = d;
    endtask

    task automatic do_reset();
        idle_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    logic [31:0] exp_cyc;

    initial begin
        idle_in();
        wb_first = 0;
        cmp_en = 1;
        tick(2);
        rst = 0;
        chk("rst_done", done, 0);
        chk("rst_commit", commit_cnt, 0);

        // Rotated slot order: slot1 is oldest.
        wb_first = 1;
        set_slot(0, 32'hbfc00000, 4'hf, 5'd1, 32'd5);
        set_slot(1, 32'hbfc00004, 4'hf, 5'd2, 32'd6);
        tick(); idle_in();
        set_ref(32'hbfc00004, 5'd2, 32'd6); tick();
        set_ref(32'hbfc00000, 5'd1, 32'd5); tick();
        idle_in(); tick();
        chk("t1_commit_cnt", commit_cnt, 2);
        chk("t1_err", err, 0);

        // Unrotated order against the rotated reference -> mismatch on first record.
        do_reset();
        wb_first = 0;
        set_slot(0, 32'hbfc00000, 4'hf, 5'd1, 32'd5);
        set_slot(1, 32'hbfc00004, 4'hf, 5'd2, 32'd6);
        tick(); idle_in();
        set_ref(32'hbfc00004, 5'd2, 32'd6); tick();
        idle_in(); tick();
        chk("t2_err", err, 1);
        chk("t2_err_pc", err_pc, 32'hbfc00000);
        chk("t2_err_wdata", err_wdata, 32'd5);
        chk("t2_pass", pass, 0);
        chk("t2_done", done, 1);

        // Overflow: DEPTH 4, two commits per cycle, no golden records.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_slot(0, 32'h100 + 32'(8*c), 4'hf, 5'd3, 32'(c));
            set_slot(1, 32'h104 + 32'(8*c), 4'hf, 5'd4, 32'(c + 10));
            tick();
            chk("t3_err", err, (c == 2) ? 32'd1 : 32'd0);
        end
        idle_in(); tick();
        chk("t3_ready", ref_ready, 0);
        chk("t3_err_pc", err_pc, 0);

        // Drain: 3 queued, trigger via non-qualifying END_PC slot plus one same-cycle commit.
        do_reset();
        set_slot(0, 32'h10, 4'hf, 5'd3, 32'ha1);
        set_slot(1, 32'h14, 4'h1, 5'd4, 32'ha2);
        tick(); idle_in();
        set_slot(0, 32'h18, 4'hf, 5'd5, 32'ha3);
        set_slot(1, 32'h1c, 4'h0, 5'd6, 32'hee);
        tick(); idle_in();
        set_slot(0, END_PC, 4'h0, 5'd0, 32'd0);
        set_slot(1, 32'h20, 4'hf, 5'd7, 32'ha4);
        tick(); idle_in();
        set_slot(0, 32'h40, 4'hf, 5'd9, 32'hbad);
        set_ref(32'h10, 5'd3, 32'ha1); tick(); idle_in();
        set_ref(32'h14, 5'd4, 32'ha2); tick();
        set_ref(32'h18, 5'd5, 32'ha3); tick();
        set_ref(32'h20, 5'd7, 32'ha4); tick();
        idle_in();
        chk("t4_done_early", done, 0);
        tick();
        chk("t4_done", done, 1);
        chk("t4_pass", pass, 1);
        chk("t4_commit_cnt", commit_cnt, 4);

        // UART end marker; other bytes ignored.
        do_reset();
        uart_valid = 1; uart_data = 8'h41; tick(); idle_in(); tick(3);
        chk("t5_no_end", done, 0);
        uart_valid = 1; uart_data = 8'hff; tick(); idle_in();
        chk("t5_done_1cyc", done, 0);
        tick();
        chk("t5_done", done, 1);
        chk("t5_pass", pass, 1);

        // Reset mid-drain discards queue.
        do_reset();
        set_slot(0, 32'h60, 4'hf, 5'd1, 32'd1);
        set_slot(1, 32'h64, 4'hf, 5'd2, 32'd2);
        tick(); idle_in();
        uart_valid = 1; uart_data = 8'hff; tick(); idle_in();
        tick(2);
        chk("t6_wait", done, 0);
        rst = 1; tick();
        chk("t6_rst_done", done, 0);
        chk("t6_rst_err", err, 0);
        chk("t6_rst_cyc", cycle_cnt, 0);
        rst = 0;
        uart_valid = 1; uart_data = 8'hff; tick(); idle_in(); tick();
        chk("t6_done", done, 1);
        chk("t6_pass", pass, 1);
`ifdef WB_TRACE_PERF_EN
        exp_cyc = 32'd2;
`else
        exp_cyc = 32'd0;
`endif
        chk("t6_cycle_cnt", cycle_cnt, exp_cyc);

        // wnum mismatch in the same cycle as an end trigger: error wins.
        do_reset();
        set_slot(0, 32'h50, 4'hf, 5'd8, 32'h77);
        tick(); idle_in();
        set_ref(32'h50, 5'd9, 32'h77);
        set_slot(0, END_PC, 4'h0, 5'd0, 32'd0);
        tick(); idle_in(); tick();
        chk("t7_err", err, 1);
        chk("t7_pass", pass, 0);
        chk("t7_err_pc", err_pc, 32'h50);
        chk("t7_err_wdata", err_wdata, 32'h77);

        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
